// File: rtl/clk_div_bank.sv
// Multi-channel divided-clock generator on refclk with run-time divide/phase
// reconfiguration; all lanes restart together on ALIGN, then wait out a lock window.

module clk_div_lane #(
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             align_i,
  input  logic             en_i,
  output logic             outclk_o,
  output logic             outclk_en_o
);
  logic [DIV_W-1:0] div_q, phase_q, cnt_q, cnt_d;
  logic [DIV_W-1:0] n_eff, p_eff, load, half;
  logic             outclk_q, strobe_q;

  // Ratios below 2 collapse to a toggle; out-of-range phase means no offset.
  assign n_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign p_eff = (phase_q < n_eff) ? phase_q : '0;
  assign load  = (p_eff != '0) ? (n_eff - p_eff) : '0;
  assign half  = n_eff >> 1;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (cnt_q >= n_eff - DIV_W'(1)) cnt_d = '0;
    if (align_i || !en_i)           cnt_d = load;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q    <= DIV_W'(DIV_INIT);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      if (wr_i) begin
        div_q   <= div_i;
        phase_q <= phase_i;
      end
      cnt_q    <= cnt_d;
      // Outputs follow the counter value being written this edge.
      outclk_q <= en_i && (cnt_d < half);
      strobe_q <= en_i && (cnt_d == '0);
    end
  end

  assign outclk_o    = outclk_q;
  assign outclk_en_o = strobe_q;
endmodule

module clk_div_bank #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_INIT    = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CH_W-1:0]       cfg_chan_i,
  input  logic [DIV_W-1:0]      cfg_div_i,
  input  logic [DIV_W-1:0]      cfg_phase_i,
  input  logic [NUM_CLOCKS-1:0] chan_en_i,
  output logic [NUM_CLOCKS-1:0] outclk_o,
  output logic [NUM_CLOCKS-1:0] outclk_en_o,
  output logic                  locked_o
);
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_ALIGN, S_WAIT, S_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [LC_W-1:0] lc_q, lc_d;
  logic            hs, align;

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    hs      = 1'b0;
    align   = 1'b0;
    case (state_q)
      S_ALIGN: begin
        align   = 1'b1;
        lc_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        lc_d = lc_q + LC_W'(1);
        if (lc_q == LC_W'(LOCK_CYCLES - 1)) state_d = S_LOCKED;
      end
      S_LOCKED: begin
        hs = cfg_valid_i;
        if (hs) state_d = S_ALIGN;
      end
      default: state_d = S_ALIGN;
    endcase
  end

  always_ff @(posedge refclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_ALIGN;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
    end
  end

  assign locked_o    = (state_q == S_LOCKED);
  assign cfg_ready_o = (state_q == S_LOCKED);

  // A channel index beyond the bank matches no lane, so it only forces a relock.
  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_lane
    clk_div_lane #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_lane (
      .clk_i      (refclk_i),
      .rst_n_i    (rst_n_i),
      .wr_i       (hs && (cfg_chan_i == CH_W'(g))),
      .div_i      (cfg_div_i),
      .phase_i    (cfg_phase_i),
      .align_i    (align),
      .en_i       (chan_en_i[g]),
      .outclk_o   (outclk_o[g]),
      .outclk_en_o(outclk_en_o[g])
    );
  end
endmodule
